fetch_sequencer: RTL and testbench

- Program-counter sequencer and read-port arbiter for the single-port, combinationally-read instruction memory (word index = Address[8:2]).
- Fetch sequencing: advances the PC, registers the fetched word into the IF/ID boundary, and handles stall, flush and branch redirect.
- Port sharing: grants the memory read port to a debug/loader requester with bounded starvation.

---
 rtl/fetch_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// PC sequencer and instruction-memory read-port arbiter.
// Shares the single memory port between instruction fetch and a debug/loader requester.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        DbgReq,
  input  logic [31:0] DbgAddr,
  output logic        DbgGnt,
  output logic        DbgValid,
  output logic [31:0] DbgData,
  output logic [31:0] MemAddr,
  input  logic [31:0] MemData,
  output logic [31:0] PC,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PCPlus4,
  output logic        IF_Valid,
  output logic        AddrError
);

  typedef enum logic [1:0] {
    S_WARM,
    S_FETCH,
    S_DBG
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT - 1);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc4;
  logic        r_if_valid;
  logic        r_dbg_valid;
  logic [31:0] r_dbg_data;
  logic        r_addr_err;
  logic [3:0]  r_starve;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_if_instr_nxt;
  logic [31:0] w_if_pc4_nxt;
  logic        w_if_valid_nxt;
  logic        w_dbg_valid_nxt;
  logic [31:0] w_dbg_data_nxt;
  logic        w_addr_err_nxt;
  logic [3:0]  w_starve_nxt;
  logic [31:0] w_mem_addr;
  logic        w_dbg_gnt;
  logic        w_grant;
  logic        w_bubble;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_grant    = (r_state == S_FETCH) && DbgReq && (Stall || (r_starve == STARVE_MAX));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_WARM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_if_instr_nxt  = r_if_instr;
    w_if_pc4_nxt    = r_if_pc4;
    w_if_valid_nxt  = r_if_valid;
    w_dbg_valid_nxt = 1'b0;
    w_dbg_data_nxt  = r_dbg_data;
    w_addr_err_nxt  = r_addr_err;
    w_starve_nxt    = DbgReq ? r_starve : '0;
    w_mem_addr      = r_pc;
    w_dbg_gnt       = 1'b0;
    w_bubble        = 1'b0;

    case (r_state)
      S_WARM: begin
        w_state_nxt = S_FETCH;
      end

      S_FETCH: begin
        w_state_nxt  = w_grant ? S_DBG : S_FETCH;
        w_starve_nxt = (DbgReq && !w_grant) ? (r_starve + 4'd1) : '0;
        if (!Stall) begin
          w_pc_nxt = w_pc_plus4;
        end
        // A squashed fetch must leave IF_PCPlus4 untouched, so capture is gated here.
        if (!Stall && !Flush && !BranchTaken) begin
          w_if_instr_nxt = MemData;
          w_if_pc4_nxt   = w_pc_plus4;
          w_if_valid_nxt = 1'b1;
        end
      end

      S_DBG: begin
        w_state_nxt     = S_FETCH;
        w_mem_addr      = DbgAddr;
        w_dbg_gnt       = 1'b1;
        w_dbg_data_nxt  = MemData;
        w_dbg_valid_nxt = 1'b1;
        w_bubble        = 1'b1;
      end

      default: begin
        w_state_nxt = S_WARM;
      end
    endcase

    if (r_state != S_WARM) begin
      if (BranchTaken) begin
        w_pc_nxt       = {BranchTarget[31:2], 2'b00};
        w_addr_err_nxt = r_addr_err | (|BranchTarget[1:0]);
        w_bubble       = 1'b1;
      end else if (Flush) begin
        w_bubble = 1'b1;
      end
    end

    if (w_bubble) begin
      w_if_instr_nxt = NOP_WORD;
      w_if_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pc        <= RESET_PC;
      r_if_instr  <= NOP_WORD;
      r_if_pc4    <= '0;
      r_if_valid  <= 1'b0;
      r_dbg_valid <= 1'b0;
      r_dbg_data  <= '0;
      r_addr_err  <= 1'b0;
      r_starve    <= '0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_if_instr  <= w_if_instr_nxt;
      r_if_pc4    <= w_if_pc4_nxt;
      r_if_valid  <= w_if_valid_nxt;
      r_dbg_valid <= w_dbg_valid_nxt;
      r_dbg_data  <= w_dbg_data_nxt;
      r_addr_err  <= w_addr_err_nxt;
      r_starve    <= w_starve_nxt;
    end
  end

  assign MemAddr        = w_mem_addr;
  assign DbgGnt         = w_dbg_gnt;
  assign DbgValid       = r_dbg_valid;
  assign DbgData        = r_dbg_data;
  assign PC             = r_pc;
  assign IF_Instruction = r_if_instr;
  assign IF_PCPlus4     = r_if_pc4;
  assign IF_Valid       = r_if_valid;
  assign AddrError      = r_addr_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer: a cycle-level reference model
// pushes expected outputs per clock; a monitor pops and compares after each edge.
module tb_fetch_sequencer;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          LIM   = 4;
  localparam int          PH_WARM = 0;
  localparam int          PH_RUN  = 1;
  localparam int          PH_DBG  = 2;

  logic        Clk;
  logic        Reset;
  logic        Stall;
  logic        Flush;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        DbgReq;
  logic [31:0] DbgAddr;
  logic        DbgGnt;
  logic        DbgValid;
  logic [31:0] DbgData;
  logic [31:0] MemAddr;
  logic [31:0] MemData;
  logic [31:0] PC;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PCPlus4;
  logic        IF_Valid;
  logic        AddrError;

  logic [31:0] mem [128];
  assign MemData = mem[MemAddr[8:2]];

  fetch_sequencer #(
    .RESET_PC    (RPC),
    .STARVE_LIMIT(LIM),
    .NOP_WORD    (NOP)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Stall         (Stall),
    .Flush         (Flush),
    .BranchTaken   (BranchTaken),
    .BranchTarget  (BranchTarget),
    .DbgReq        (DbgReq),
    .DbgAddr       (DbgAddr),
    .DbgGnt        (DbgGnt),
    .DbgValid      (DbgValid),
    .DbgData       (DbgData),
    .MemAddr       (MemAddr),
    .MemData       (MemData),
    .PC            (PC),
    .IF_Instruction(IF_Instruction),
    .IF_PCPlus4    (IF_PCPlus4),
    .IF_Valid      (IF_Valid),
    .AddrError     (AddrError)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ifi;
    logic [31:0] ifp4;
    logic [31:0] dbgd;
    logic [31:0] maddr;
    logic        ifv;
    logic        dbgv;
    logic        gnt;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: what the outputs should read in the current cycle.
  int          m_phase;
  logic [31:0] m_pc, m_ifi, m_ifp4, m_dbgd;
  logic        m_ifv, m_dbgv, m_err;
  int          m_starve;

  task automatic model_reset();
    m_phase = PH_WARM; m_pc = RPC; m_ifi = NOP; m_ifp4 = '0; m_ifv = 1'b0;
    m_dbgv = 1'b0; m_dbgd = '0; m_err = 1'b0; m_starve = 0;
  endtask

  task automatic squash();
    m_ifv = 1'b0;
    m_ifi = NOP;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    logic [31:0] cur;
    logic        grant;
    exp_t        e;
    if (!Reset) begin
      model_reset();
    end else begin
      cur    = m_pc;
      m_dbgv = 1'b0;
      if (m_phase == PH_WARM) begin
        m_phase = PH_RUN;
      end else if (m_phase == PH_RUN) begin
        grant    = DbgReq && (Stall || m_starve == LIM - 1);
        m_starve = (DbgReq && !grant) ? m_starve + 1 : 0;
        if (BranchTaken) begin
          if (BranchTarget[1:0] != 2'b00) m_err = 1'b1;
          m_pc = BranchTarget & 32'hFFFF_FFFC;
          squash();
        end else if (Stall) begin
          if (Flush) squash();
        end else begin
          if (Flush) squash();
          else begin
            m_ifi  = mem[cur[8:2]];
            m_ifp4 = cur + 32'd4;
            m_ifv  = 1'b1;
          end
          m_pc = cur + 32'd4;
        end
        m_phase = grant ? PH_DBG : PH_RUN;
      end else begin
        m_dbgd = mem[DbgAddr[8:2]];
        m_dbgv = 1'b1;
        squash();
        if (BranchTaken) begin
          if (BranchTarget[1:0] != 2'b00) m_err = 1'b1;
          m_pc = BranchTarget & 32'hFFFF_FFFC;
        end
        if (!DbgReq) m_starve = 0;
        m_phase = PH_RUN;
      end
    end
    e.pc = m_pc; e.ifi = m_ifi; e.ifp4 = m_ifp4; e.ifv = m_ifv;
    e.dbgv = m_dbgv; e.dbgd = m_dbgd; e.err = m_err;
    e.gnt   = (m_phase == PH_DBG);
    e.maddr = (m_phase == PH_DBG) ? DbgAddr : m_pc;
    q.push_back(e);
  endtask

  always @(posedge Clk) begin : monitor
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("PC",             PC,             e.pc);
      chk("IF_Valid",       32'(IF_Valid),  32'(e.ifv));
      chk("IF_Instruction", IF_Instruction, e.ifi);
      chk("IF_PCPlus4",     IF_PCPlus4,     e.ifp4);
      chk("DbgValid",       32'(DbgValid),  32'(e.dbgv));
      chk("DbgData",        DbgData,        e.dbgd);
      chk("DbgGnt",         32'(DbgGnt),    32'(e.gnt));
      chk("MemAddr",        MemAddr,        e.maddr);
      chk("AddrError",      32'(AddrError), 32'(e.err));
    end
  end

  initial begin : stimulus
    int   rst_hold;
    int   n_rst;
    logic req_on;
    int   r;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    Reset = 1'b0; Stall = 1'b0; Flush = 1'b0; BranchTaken = 1'b0;
    BranchTarget = '0; DbgReq = 1'b0; DbgAddr = '0;
    model_reset();
    rst_hold = 2;
    n_rst    = 0;
    req_on   = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge Clk);
      if (rst_hold > 0) begin
        Reset = 1'b0;
        rst_hold--;
      end else if (m_phase == PH_DBG && n_rst < 4 && cyc > 40) begin
        // Abort an in-flight debug read; outputs must clear without waiting for a clock.
        Reset = 1'b0;
        rst_hold = 1;
        n_rst++;
        #1;
        chk("async PC",       PC,                 RPC);
        chk("async IF_Valid", 32'(IF_Valid),      32'd0);
        chk("async IF_Instr", IF_Instruction,     NOP);
        chk("async DbgGnt",   32'(DbgGnt),        32'd0);
        chk("async DbgValid", 32'(DbgValid),      32'd0);
        chk("async DbgData",  DbgData,            32'd0);
        chk("async AddrErr",  32'(AddrError),     32'd0);
      end else begin
        Reset = 1'b1;
      end

      if (m_dbgv) req_on = 1'b0;
      if (cyc < 14) begin
        Stall = 1'b0; Flush = 1'b0; BranchTaken = 1'b0;
      end else begin
        if (!req_on && $urandom_range(0, 99) < 15) begin
          req_on  = 1'b1;
          DbgAddr = $urandom;
        end
        Stall       = ($urandom_range(0, 99) < 25);
        Flush       = ($urandom_range(0, 99) < 10);
        BranchTaken = ($urandom_range(0, 99) < 10);
        r = $urandom_range(0, 7);
        if (r == 0)      BranchTarget = {22'd0, 10'($urandom_range(0, 1023))};
        else if (r == 1) BranchTarget = 32'hFFFF_FFF0 | {28'd0, 2'($urandom_range(2, 3)), 2'b00};
        else             BranchTarget = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end
      DbgReq = req_on;
      model_step();
    end

    repeat (3) @(negedge Clk);
    chk("scoreboard drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
